// File: rtl/intr_pkg.sv
// Shared types and helpers for the multi-source interrupt controller.
package intr_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REQ    = 2'd1;
    localparam state_t ST_INSERV = 2'd2;

    // Vector width for n sources, never narrower than one bit.
    function automatic int unsigned vec_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module intr_prio_enc #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned VEC_W = 2
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             any_o,
    output logic [VEC_W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = VEC_W'(i);
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected sources, pending/mask/overrun state,
// and an irr/ack/eoi handshake toward the CPU.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter  int unsigned N_SRC = 4,
    localparam int unsigned VEC_W = vec_width(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    output logic             irr,
    output logic [VEC_W-1:0] vec,
    input  logic             ack,
    input  logic             eoi,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic [N_SRC-1:0] ovr_clr,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] ovr
);

    logic [N_SRC-1:0] src_q, pending_q, pending_d, mask_q, mask_d, ovr_q, ovr_d;
    logic [N_SRC-1:0] evt, clr, eligible;
    state_t           state_q, state_d;
    logic             irr_q, irr_d;
    logic [VEC_W-1:0] vec_q, vec_d, win_idx;
    logic             win_any;
    logic             take;

    assign eligible = pending_q & ~mask_q;

    intr_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio (
        .req_i (eligible),
        .any_o (win_any),
        .idx_o (win_idx)
    );

    // A new event on the acknowledged source re-arms it instead of overrunning.
    always_comb begin
        evt       = src & ~src_q;
        take      = (state_q == ST_REQ) && ack;
        clr       = '0;
        if (take) clr[vec_q] = 1'b1;
        pending_d = (pending_q & ~clr) | evt;
        ovr_d     = (ovr_q & ~ovr_clr) | (evt & pending_q & ~clr);
        mask_d    = mask_we ? mask_wdata : mask_q;

        state_d = state_q;
        irr_d   = irr_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_REQ;
                    irr_d   = 1'b1;
                    vec_d   = win_idx;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_INSERV;
                    irr_d   = 1'b0;
                end
            end
            ST_INSERV: begin
                if (eoi) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                irr_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ovr_q     <= '0;
            state_q   <= ST_IDLE;
            irr_q     <= 1'b0;
            vec_q     <= '0;
        end else begin
            src_q     <= src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            irr_q     <= irr_d;
            vec_q     <= vec_d;
        end
    end

    assign irr     = irr_q;
    assign vec     = vec_q;
    assign pending = pending_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the controller.
module tb_intr_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;
    logic         irr;
    logic [1:0]   vec;
    logic         ack;
    logic         eoi;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic [N-1:0] ovr_clr;
    logic [N-1:0] pending;
    logic [N-1:0] ovr;

    always #5 clk = ~clk;

    intr_ctrl #(.N_SRC(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .irr        (irr),
        .vec        (vec),
        .ack        (ack),
        .eoi        (eoi),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ovr_clr    (ovr_clr),
        .pending    (pending),
        .ovr        (ovr)
    );

    typedef struct packed {
        logic         irr;
        logic [1:0]   vec;
        logic [N-1:0] pend;
        logic [N-1:0] ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: per-source flags plus a handshake phase
    // (0 = waiting, 1 = request shown to CPU, 2 = handler running).
    bit [N-1:0] m_pend, m_ovr, m_mask, m_prev;
    int         m_phase = 0;
    int         m_cur   = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    task automatic step(input logic [N-1:0] s, input logic a, input logic e,
                        input logic mwe, input logic [N-1:0] md,
                        input logic [N-1:0] oc, input logic r);
        bit [N-1:0] np, no;
        bit         acked, ev, cl;
        int         win;
        exp_t       x;
        @(negedge clk);
        src = s; ack = a; eoi = e; mask_we = mwe; mask_wdata = md; ovr_clr = oc; reset = r;
        if (r) begin
            m_pend = '0; m_ovr = '0; m_mask = '0; m_prev = '0;
            m_phase = 0; m_cur = 0;
        end else begin
            acked = (m_phase == 1) && a;
            for (int i = 0; i < N; i++) begin
                ev    = s[i] && !m_prev[i];
                cl    = acked && (i == m_cur);
                np[i] = ev ? 1'b1 : (cl ? 1'b0 : m_pend[i]);
                no[i] = (ev && m_pend[i] && !cl) ? 1'b1 : (oc[i] ? 1'b0 : m_ovr[i]);
            end
            win = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && !m_mask[i]) win = i;
            case (m_phase)
                0: if (win >= 0) begin m_phase = 1; m_cur = win; end
                1: if (a) m_phase = 2;
                default: if (e) m_phase = 0;
            endcase
            m_pend = np;
            m_ovr  = no;
            m_prev = s;
            if (mwe) m_mask = md;
        end
        x.irr  = (m_phase == 1);
        x.vec  = 2'(m_cur);
        x.pend = m_pend;
        x.ovr  = m_ovr;
        exp_q.push_back(x);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse(input logic [N-1:0] s);
        step(s, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_ack();
        step('0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_eoi();
        step('0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compares every registered output one step after stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("irr", int'(irr), int'(x.irr));
                if (x.irr) chk("vec", int'(vec), int'(x.vec));
                chk("pending", int'(pending), int'(x.pend));
                chk("ovr", int'(ovr), int'(x.ovr));
            end
        end
    end

    initial begin
        logic [N-1:0] s_hold;
        src = '0; ack = 0; eoi = 0; mask_we = 0; mask_wdata = '0; ovr_clr = '0; reset = 1;
        step('0, 0, 0, 0, '0, '0, 1'b1);
        step('0, 0, 0, 0, '0, '0, 1'b1);

        // single source: request, ack, eoi
        pulse(4'b0100); nop(2); do_ack(); nop(1); do_eoi(); nop(3);

        // two sources at once: lower index first, then the other
        pulse(4'b1010); nop(2); do_ack(); do_eoi(); nop(3); do_ack(); do_eoi(); nop(2);

        // masked pending stays latched until unmasked
        step('0, 0, 0, 1'b1, 4'b0010, '0, 1'b0);
        pulse(4'b0010); nop(3);
        step('0, 0, 0, 1'b1, 4'b0000, '0, 1'b0);
        nop(3); do_ack(); do_eoi(); nop(2);

        // overrun, clear, and event coinciding with ack
        pulse(4'b0001); pulse(4'b0000); pulse(4'b0001); nop(1);
        step('0, 0, 0, 0, '0, 4'b0001, 1'b0);
        nop(1);
        step(4'b0001, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        nop(1); do_eoi(); nop(3); do_ack(); do_eoi(); nop(2);

        // reset while a request is outstanding, then stray ack/eoi
        pulse(4'b1010); nop(2);
        step('0, 0, 0, 0, '0, '0, 1'b1);
        do_ack(); do_eoi(); nop(2);

        // level held high gives exactly one event
        for (int i = 0; i < 10; i++) pulse(4'b0100);
        nop(2); do_ack(); do_eoi(); nop(2);

        // random traffic
        s_hold = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) s_hold = 4'($urandom_range(0, 15));
            step(s_hold,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 $urandom_range(0, 199) == 0);
        end

        nop(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised multi-source interrupt controller that supersedes the single-source UART interrupt latch between peripherals and the CPU. It edge-detects N source lines, latches pending events, applies a software mask, presents the highest-priority unmasked request to the CPU on an irr/ack handshake with a vector number, and holds further requests until the handler signals end-of-interrupt. Lost events are recorded in sticky overrun bits.

## Interface
- N_SRC, default 4: number of interrupt sources, 1..32.
- VEC_W, default $clog2(N_SRC) (minimum 1): vector width, derived and not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- src  in  N_SRC  source lines (e.g. uart_update); an event is a 0->1 transition
- irr  out  1  interrupt request to CPU
- vec  out  VEC_W  source index of the current request; valid while irr=1
- ack  in  1  CPU accepts current request (single-cycle pulse)
- eoi  in  1  CPU handler finished (single-cycle pulse)
- mask_we  in  1  write strobe for mask
- mask_wdata  in  N_SRC  new mask; bit=1 disables that source
- ovr_clr  in  N_SRC  write-1-to-clear for overrun bits
- pending  out  N_SRC  pending bitmap, readback
- ovr  out  N_SRC  sticky overrun bitmap, readback

## Operation
- Edge detect: src_q registers src; event[i] = src[i] & ~src_q[i].
- Pending: event[i] sets pending[i] regardless of mask. Event while pending[i]=1 sets ovr[i] (unless same cycle clears pending[i], see below).
- Mask: mask_we loads mask_wdata next edge. Masked pending bits stay latched; unmasking later makes them eligible.
- Priority: fixed, lowest index wins among pending & ~mask.
- FSM states IDLE, REQ, INSERV:
  - IDLE: if any eligible, latch vec = winner, irr<=1, go REQ.
  - REQ: irr=1, vec frozen (mask changes do not retract). On ack: clear pending[vec], irr<=0, go INSERV.
  - INSERV: no new request. On eoi: go IDLE.
- ack outside REQ and eoi outside INSERV are ignored.
- Same-cycle event on source vec and ack: set wins; pending[vec] stays 1, ovr not set.
- ovr_clr[i] clears ovr[i]; simultaneous overrun event wins (ovr stays 1).
- Reset: src_q=0, pending=0, ovr=0, mask=0 (all enabled), irr=0, vec=0, state IDLE. Reset mid-REQ/INSERV drops everything; no request survives.

## Timing
- src rises in cycle t -> pending bit visible t+1 -> irr=1, vec valid t+2 (from IDLE).
- ack sampled in cycle a -> irr=0 and pending cleared at a+1.
- eoi sampled in cycle e -> IDLE at e+1 -> earliest next irr at e+2.
- mask_we in cycle m affects winner selection from m+1.
- All outputs registered; no combinational path from any input to irr/vec.

## Structure
- Package intr_pkg: state enum (IDLE, REQ, INSERV) as typedef logic [1:0].
- Sub-module intr_prio_enc: parametrised combinational lowest-index priority encoder (req[N_SRC] -> any, idx[VEC_W]).
- Top intr_ctrl holds edge detect, pending/mask/ovr registers and FSM.

## Test plan
- N_SRC=4, pulse src[2] at t -> pending=0100 at t+1, irr=1 vec=2 at t+2; ack -> irr=0, pending=0000; eoi -> IDLE, irr stays 0.
- Pulse src[3] and src[1] same cycle -> vec=1 first; after ack+eoi, vec=3 two cycles after eoi.
- mask=0010, pulse src[1] -> pending=0010, irr stays 0; write mask=0000 -> irr=1 vec=1 two cycles later.
- Pulse src[0] twice before ack -> ovr=0001; ovr_clr=0001 -> ovr=0000; pulse src[0] in same cycle as ack on vec=0 -> pending[0]=1 after ack, ovr=0000.
- Assert reset while in REQ with pending=1010 -> next cycle irr=0, pending=0000, ovr=0000, state IDLE; ack/eoi pulses in IDLE have no effect.
- Hold src[2] high for 10 cycles -> exactly one event; pending set once, no overrun.
